// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte producers, the arbiter and the UART transmitter FSM.
// master = arbiter side, slave = producers/transmitter side.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    localparam int IW = $clog2(NREQ);

    logic                 arb_enable;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 tx_enable;
    logic [DW-1:0]        tx_data;
    logic                 tx_load;
    logic                 tx_busy;
    logic [IW-1:0]        grant_id;
    logic                 frame_done;
    logic                 tx_err;

    modport master (
        input  arb_enable, req_valid, req_data, tx_load, tx_busy,
        output req_ready, tx_enable, tx_data, grant_id, frame_done, tx_err
    );

    modport slave (
        output arb_enable, req_valid, req_data, tx_load, tx_busy,
        input  req_ready, tx_enable, tx_data, grant_id, frame_done, tx_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter: one frame per grant, one-cycle gap between frames.
// Optional START timeout abort enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              fsm_clk,
    input  logic              rst_n,
    uart_tx_arbiter_if.master bus
);
    localparam int IW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("uart_tx_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
    end

    typedef enum logic [1:0] {IDLE, START, SEND, GAP} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [DW-1:0]   data_q, data_d;
    logic            txen_q, txen_d;
    logic [IW-1:0]   win;
    logic            any_valid;
    logic [NREQ-1:0] ready;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          abort_q, abort_d;
`endif

    // Descending scan so the candidate nearest to ptr (smallest offset) wins.
    always_comb begin
        int idx;
        idx       = 0;
        any_valid = 1'b0;
        win       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (bus.req_valid[idx]) begin
                any_valid = 1'b1;
                win       = IW'(idx);
            end
        end
    end

    always_comb begin
        ready = '0;
        if (rst_n && state_q == IDLE && bus.arb_enable && any_valid) begin
            ready[win] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        data_d  = data_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        abort_d = abort_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.arb_enable && any_valid) begin
                    data_d  = bus.req_data[int'(win)*DW +: DW];
                    grant_d = win;
                    state_d = START;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    cnt_d   = '0;
                    abort_d = 1'b0;
`endif
                end
            end
            START: begin
                if (bus.tx_load) begin
                    state_d = SEND;
`ifdef UART_TX_ARB_TIMEOUT_EN
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = GAP;
                    abort_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
`endif
                end
            end
            SEND: begin
                if (!bus.tx_busy) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                ptr_d   = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + IW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Registered enable: follows the state being entered, so it is high exactly in START/SEND.
        txen_d = (state_d == START) || (state_d == SEND);
    end

    always_ff @(posedge fsm_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            data_q  <= '0;
            txen_q  <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            abort_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            txen_q  <= txen_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
`endif
        end
    end

    assign bus.req_ready = ready;
    assign bus.tx_enable = txen_q;
    assign bus.tx_data   = data_q;
    assign bus.grant_id  = grant_q;

`ifdef UART_TX_ARB_TIMEOUT_EN
    assign bus.frame_done = (state_q == GAP) && !abort_q;
    assign bus.tx_err     = (state_q == GAP) && abort_q;
`else
    assign bus.frame_done = (state_q == GAP);
    assign bus.tx_err     = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small behavioural UART transmitter model.
// The START-timeout sequence runs only when UART_TX_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;
    localparam int NREQ      = 4;
    localparam int DW        = 8;
    localparam int TIMEOUT   = 15;
    localparam int FRAME_LEN = 10;

    localparam logic [1:0] M_IDLE  = 2'd0;
    localparam logic [1:0] M_LOAD  = 2'd1;
    localparam logic [1:0] M_SHIFT = 2'd2;
    localparam logic [1:0] M_DONE  = 2'd3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus();

    uart_tx_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .fsm_clk (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Transmitter model: LOAD one cycle, SHIFT FRAME_LEN cycles, then wait for enable to drop.
    logic [1:0] mstate = M_IDLE;
    int         mcnt   = 0;
    int         n_load = 0;
    logic       stuck  = 1'b0;

    assign bus.tx_load = (mstate == M_LOAD);
    assign bus.tx_busy = (mstate == M_LOAD) || (mstate == M_SHIFT);

    always @(posedge clk) begin
        if (!bus.tx_enable || stuck) begin
            mstate <= M_IDLE;
        end else begin
            case (mstate)
                M_IDLE:  begin mstate <= M_LOAD; n_load <= n_load + 1; end
                M_LOAD:  begin mstate <= M_SHIFT; mcnt <= FRAME_LEN - 1; end
                M_SHIFT: begin
                    if (mcnt == 0) mstate <= M_DONE;
                    else           mcnt   <= mcnt - 1;
                end
                default: mstate <= M_DONE;
            endcase
        end
    end

    // Observer: pulse counters, grant order, byte per completed frame, enable-low run lengths.
    int         n_done = 0;
    int         n_err  = 0;
    int         grant_log[$];
    logic [7:0] data_log[$];
    int         gap_log[$];
    logic       prev_en   = 1'b0;
    logic       seen_high = 1'b0;
    int         low_run   = 0;

    function automatic int oh2i(logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(posedge clk) begin
        n_done <= n_done + int'(bus.frame_done);
        n_err  <= n_err + int'(bus.tx_err);
        if (|bus.req_ready) grant_log.push_back(oh2i(bus.req_ready));
        if (bus.frame_done) data_log.push_back(bus.tx_data);
        if (bus.tx_enable) begin
            if (!prev_en && seen_high) gap_log.push_back(low_run);
            seen_high <= 1'b1;
            low_run   <= 0;
        end else begin
            low_run <= low_run + 1;
        end
        prev_en <= bus.tx_enable;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic bound_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timed out", nm);
    endtask

    task automatic wait_grants(input int target, input string nm);
        int c = 0;
        while (grant_log.size() < target && c < 1000) begin @(negedge clk); c++; end
        if (grant_log.size() < target) bound_fail(nm);
    endtask

    task automatic wait_done(input int target, input string nm);
        int c = 0;
        while (n_done < target && c < 1000) begin @(negedge clk); c++; end
        if (n_done < target) bound_fail(nm);
    endtask

    task automatic wait_send(input string nm);
        int c = 0;
        while (!(bus.tx_busy && !bus.tx_load) && c < 100) begin @(negedge clk); c++; end
        if (!(bus.tx_busy && !bus.tx_load)) bound_fail(nm);
    endtask

    typedef struct {
        logic            arb;
        logic [NREQ-1:0] valid;
        logic [NREQ-1:0] exp_ready;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int d0, l0, g0, gs, e0, first_k, bad;

        // Winner selection with ptr=0 straight after reset.
        vecs[0] = '{1'b1, 4'b0000, 4'b0000};
        vecs[1] = '{1'b1, 4'b0001, 4'b0001};
        vecs[2] = '{1'b1, 4'b0110, 4'b0010};
        vecs[3] = '{1'b1, 4'b1000, 4'b1000};
        vecs[4] = '{1'b1, 4'b1111, 4'b0001};
        vecs[5] = '{1'b0, 4'b1111, 4'b0000};
        vecs[6] = '{1'b1, 4'b1100, 4'b0100};
        vecs[7] = '{1'b1, 4'b1010, 4'b0010};

        bus.arb_enable = 1'b0;
        bus.req_valid  = '0;
        bus.req_data   = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_tx_enable", 32'(bus.tx_enable), 0);
        chk("rst_tx_data", 32'(bus.tx_data), 0);
        chk("rst_grant_id", 32'(bus.grant_id), 0);
        chk("rst_frame_done", 32'(bus.frame_done), 0);
        chk("rst_tx_err", 32'(bus.tx_err), 0);
        chk("rst_req_ready", 32'(bus.req_ready), 0);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.arb_enable = vecs[i].arb;
            bus.req_valid  = vecs[i].valid;
            #1;
            chk($sformatf("vec%0d_ready", i), 32'(bus.req_ready), 32'(vecs[i].exp_ready));
            #1;
            bus.req_valid = '0;
        end
        chk("vec_no_grant", 32'(grant_log.size()), 0);

        // Single grant of requester 2.
        @(negedge clk);
        bus.arb_enable = 1'b1;
        bus.req_data   = {8'h00, 8'hA5, 8'h00, 8'h00};
        bus.req_valid  = 4'b0100;
        d0 = n_done; l0 = n_load;
        #1;
        chk("s1_ready", 32'(bus.req_ready), 32'h4);
        @(negedge clk);
        bus.req_valid = '0;
        chk("s1_tx_data", 32'(bus.tx_data), 32'hA5);
        chk("s1_grant_id", 32'(bus.grant_id), 2);
        chk("s1_tx_enable", 32'(bus.tx_enable), 1);
        wait_done(d0 + 1, "s1_done");
        repeat (6) @(negedge clk);
        chk("s1_done_count", 32'(n_done - d0), 1);
        chk("s1_load_count", 32'(n_load - l0), 1);
        chk("s1_enable_low", 32'(bus.tx_enable), 0);
        chk("s1_frame_byte", 32'(data_log[$]), 32'hA5);

        // Fresh reset, all four requesters held: order 0,1,2,3,0 with two-cycle enable gaps.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.req_valid = 4'b1111;
        g0 = grant_log.size(); d0 = n_done; gs = gap_log.size();
        wait_grants(g0 + 5, "s2_grants");
        bus.req_valid = '0;
        wait_done(d0 + 5, "s2_done");
        repeat (4) @(negedge clk);
        for (int j = 0; j < 5; j++) begin
            if (grant_log.size() > g0 + j)
                chk($sformatf("s2_order%0d", j), 32'(grant_log[g0 + j]), 32'(j % 4));
            if (data_log.size() >= 5)
                chk($sformatf("s2_byte%0d", j), 32'(data_log[data_log.size() - 5 + j]), 32'(8'h10 + (j % 4)));
        end
        chk("s2_done_count", 32'(n_done - d0), 5);
        for (int j = 1; j < 5; j++) begin
            if (gap_log.size() > gs + j) chk($sformatf("s2_gap%0d", j), 32'(gap_log[gs + j]), 2);
            else bound_fail($sformatf("s2_gap%0d", j));
        end

        // Serve 1 (ptr becomes 2), then 0 and 1 both valid: 0 first, then 1.
        bus.req_valid = 4'b0010;
        g0 = grant_log.size(); d0 = n_done;
        wait_grants(g0 + 1, "s3_serve1");
        bus.req_valid = '0;
        wait_done(d0 + 1, "s3_done1");
        @(negedge clk);
        bus.req_valid = 4'b0011;
        wait_grants(g0 + 3, "s3_pair");
        bus.req_valid = '0;
        wait_done(d0 + 3, "s3_done3");
        if (grant_log.size() >= g0 + 3) begin
            chk("s3_first", 32'(grant_log[g0 + 1]), 0);
            chk("s3_second", 32'(grant_log[g0 + 2]), 1);
        end

        // arb_enable removed during SEND: frame completes, no strobes until it returns.
        @(negedge clk);
        bus.req_valid = 4'b0100;
        g0 = grant_log.size(); d0 = n_done;
        wait_grants(g0 + 1, "s4_grant");
        wait_send("s4_send");
        bus.arb_enable = 1'b0;
        wait_done(d0 + 1, "s4_done");
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.req_ready != '0) bad = 1;
        end
        chk("s4_ready_held", 32'(bad), 0);
        chk("s4_grant_held", 32'(grant_log.size()), 32'(g0 + 1));
        chk("s4_enable_low", 32'(bus.tx_enable), 0);
        bus.arb_enable = 1'b1;
        #1;
        chk("s4_ready_back", 32'(bus.req_ready), 32'h4);
        wait_grants(g0 + 2, "s4_regrant");
        bus.req_valid = '0;
        wait_done(d0 + 2, "s4_done2");

        // Reset during SEND: outputs clear at once, pending request granted from ptr=0.
        @(negedge clk);
        bus.req_valid = 4'b1000;
        g0 = grant_log.size(); d0 = n_done;
        wait_grants(g0 + 1, "s5_grant");
        wait_send("s5_send");
        bus.req_valid = 4'b1010;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("s5_rst_enable", 32'(bus.tx_enable), 0);
        chk("s5_rst_ready", 32'(bus.req_ready), 0);
        chk("s5_rst_grant", 32'(bus.grant_id), 0);
        chk("s5_rst_data", 32'(bus.tx_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("s5_fresh_ready", 32'(bus.req_ready), 32'h2);
        chk("s5_no_done", 32'(n_done - d0), 0);
        wait_grants(g0 + 2, "s5_regrant");
        bus.req_valid = '0;
        wait_done(d0 + 1, "s5_done");
        chk("s5_byte", 32'(data_log[$]), 32'h11);
        chk("s5_err_quiet", 32'(n_err), 0);

`ifdef UART_TX_ARB_TIMEOUT_EN
        // tx_load never arrives: abort after TIMEOUT cycles, ptr still advances.
        @(negedge clk);
        stuck = 1'b1;
        bus.req_valid = 4'b0101;
        g0 = grant_log.size(); d0 = n_done; e0 = n_err;
        wait_grants(g0 + 1, "to_grant");
        first_k = -1;
        for (int k = 0; k < TIMEOUT + 6; k++) begin
            if (bus.tx_err && first_k < 0) first_k = k;
            @(negedge clk);
        end
        chk("to_err_cycle", 32'(first_k), 32'(TIMEOUT));
        chk("to_err_count", 32'(n_err - e0), 1);
        chk("to_no_done", 32'(n_done - d0), 0);
        stuck = 1'b0;
        wait_grants(g0 + 2, "to_next");
        bus.req_valid = '0;
        wait_done(d0 + 1, "to_done");
        if (grant_log.size() >= g0 + 2) begin
            chk("to_first", 32'(grant_log[g0]), 2);
            chk("to_next_id", 32'(grant_log[g0 + 1]), 0);
        end
`endif

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
